// File: rtl/pokey_audio_pkg.sv
// Shared constants, types and helpers for the POKEY PWM-to-I2S audio path.
package pokey_audio_pkg;

    localparam int unsigned SAMPLE_W      = 16;
    localparam int unsigned I2S_SLOT_BITS = 16;
    localparam int unsigned FRAME_BITS    = 2 * I2S_SLOT_BITS;
    localparam int unsigned PWM_PERIOD    = 64;
    localparam int unsigned ACC_W         = 11;
    localparam logic [SAMPLE_W-1:0] PCM_OFFSET = 16'h8000;

    typedef enum logic {
        IDLE,
        RUN
    } i2s_state_e;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int unsigned fifo_level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pokey_sample_fifo.sv
// Small synchronous sample FIFO with first-word-fall-through read data.
module pokey_sample_fifo
    import pokey_audio_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = SAMPLE_W
) (
    input  logic                            clk,
    input  logic                            clr,
    input  logic                            push,
    input  logic                            pop,
    input  logic [WIDTH-1:0]                din,
    output logic [WIDTH-1:0]                dout,
    output logic [fifo_level_w(DEPTH)-1:0]  level,
    output logic                            full,
    output logic                            empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = fifo_level_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign level = level_q;

    // Pop only when data exists; push when space exists or a pop frees a slot this cycle.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/pokey_i2s_bridge.sv
// POKEY PWM audio bit -> decimated 16-bit PCM -> FIFO -> mono I2S (L = R).
module pokey_i2s_bridge
    import pokey_audio_pkg::*;
#(
    parameter int unsigned DECIM      = 2048,
    parameter int unsigned BCLK_DIV   = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PRIME      = 2
) (
    input  logic                                 clk,
    input  logic                                 clr,
    input  logic                                 aud,
    input  logic                                 en,
    output logic                                 i2s_bclk,
    output logic                                 i2s_lrclk,
    output logic                                 i2s_sdata,
    output logic [SAMPLE_W-1:0]                  sample_out,
    output logic                                 sample_valid,
    output logic [fifo_level_w(FIFO_DEPTH)-1:0]  fifo_level,
    output logic                                 underflow,
    output logic                                 overflow
);

    localparam int unsigned WIN_W = $clog2(DECIM);
    localparam int unsigned DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned LVL_W = fifo_level_w(FIFO_DEPTH);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam int unsigned PAD_W = SAMPLE_W - ACC_W;

    logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
    logic [ACC_W-1:0]      acc_q, acc_d, acc_sum;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic                  valid_q, valid_d;

    i2s_state_e            state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [SAMPLE_W-1:0]   last_q, last_d;
    logic                  underflow_q, underflow_d;
    logic                  overflow_q, overflow_d;

    logic                  frame_pop;
    logic [SAMPLE_W-1:0]   fifo_dout;
    logic [LVL_W-1:0]      fifo_lvl;
    logic                  fifo_full, fifo_empty;

    pokey_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk   (clk),
        .clr   (clr),
        .push  (valid_q),
        .pop   (frame_pop),
        .din   (sample_q),
        .dout  (fifo_dout),
        .level (fifo_lvl),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decimator: saturating high-time count over one window, offset-binary to two's complement.
    always_comb begin
        acc_sum   = (&acc_q) ? acc_q : acc_q + ACC_W'(aud);
        win_cnt_d = win_cnt_q;
        acc_d     = acc_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        if (en) begin
            if (win_cnt_q == WIN_W'(DECIM - 1)) begin
                win_cnt_d = '0;
                acc_d     = '0;
                sample_d  = {acc_sum, {PAD_W{1'b0}}} ^ PCM_OFFSET;
                valid_d   = 1'b1;
            end else begin
                win_cnt_d = win_cnt_q + WIN_W'(1);
                acc_d     = acc_sum;
            end
        end
    end

    // I2S FSM: bclk divider; lrclk/sdata move on bclk falls; bit position 0 is the frame start.
    // Shifter holds {s,s}; its last remaining bit (R LSB) goes out on the next frame's first fall,
    // which yields the one-bclk data delay after each lrclk edge.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        bclk_d      = bclk_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        shift_d     = shift_q;
        last_d      = last_q;
        underflow_d = underflow_q;
        frame_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_lvl >= LVL_W'(PRIME)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (en) begin
                    if (div_cnt_q == DIV_W'(BCLK_DIV - 1)) begin
                        div_cnt_d = '0;
                        bclk_d    = ~bclk_q;
                        if (bclk_q) begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            lrclk_d   = (bit_cnt_q >= BIT_W'(I2S_SLOT_BITS));
                            sdata_d   = shift_q[FRAME_BITS-1];
                            if (bit_cnt_q == '0) begin
                                frame_pop = 1'b1;
                                if (fifo_empty) begin
                                    shift_d     = {last_q, last_q};
                                    underflow_d = 1'b1;
                                end else begin
                                    shift_d = {fifo_dout, fifo_dout};
                                    last_d  = fifo_dout;
                                end
                            end else begin
                                shift_d = shift_q << 1;
                            end
                        end
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow: a push that finds the FIFO full with no same-cycle pop is dropped.
    always_comb begin
        overflow_d = overflow_q | (valid_q & fifo_full & ~frame_pop);
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            shift_q     <= '0;
            last_q      <= '0;
            underflow_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            underflow_q <= underflow_d;
            overflow_q  <= overflow_d;
        end
    end

    assign i2s_bclk     = bclk_q;
    assign i2s_lrclk    = lrclk_q;
    assign i2s_sdata    = sdata_q;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign fifo_level   = fifo_lvl;
    assign underflow    = underflow_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_pokey_i2s_bridge.sv
// Scoreboard bench: PCM model from counted high-time, I2S decoded from the wire.
module tb_pokey_i2s_bridge;
    import pokey_audio_pkg::*;

    localparam int unsigned DECIM = 2048;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned PRIME = 2;
    localparam int unsigned B0    = 32;
    localparam int unsigned B2    = 64;

    typedef struct {
        logic [15:0] val;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic clr, aud, en;
    logic        bclk [3];
    logic        lrclk[3];
    logic        sdata[3];
    logic        sv   [3];
    logic        uf   [3];
    logic        ov   [3];
    logic [15:0] so   [3];
    logic [2:0]  lvl  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pokey_i2s_bridge #(
            .DECIM      (DECIM),
            .BCLK_DIV   ((g == 0) ? 32 : ((g == 1) ? 64 : 16)),
            .FIFO_DEPTH (DEPTH),
            .PRIME      (PRIME)
        ) dut (
            .clk          (clk),
            .clr          (clr),
            .aud          (aud),
            .en           (en),
            .i2s_bclk     (bclk[g]),
            .i2s_lrclk    (lrclk[g]),
            .i2s_sdata    (sdata[g]),
            .sample_out   (so[g]),
            .sample_valid (sv[g]),
            .fifo_level   (lvl[g]),
            .underflow    (uf[g]),
            .overflow     (ov[g])
        );
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned en_cnt = 0;
    logic clr_s = 1'b1;
    logic en_s  = 1'b0;

    exp_t        samp_q[$];
    logic [15:0] i2s_q[$];
    int unsigned ones = 0;
    int unsigned wcnt = 0;
    bit          phase_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] pcm_of(input int unsigned cnt);
        int unsigned c;
        c = (cnt > 2047) ? 2047 : cnt;
        return 16'((c * 32) ^ 32'h8000);
    endfunction

    // Event-level FIFO occupancy for the slow-frame instance, seen just before push n.
    task automatic fifo2_model(input int unsigned n, output int unsigned l, output bit o);
        int unsigned k, t0, tp;
        bit primed;
        l = 0; o = 0; k = 0; t0 = 0; primed = 0;
        for (int unsigned i = 1; i <= n; i++) begin
            tp = i * DECIM;
            while (primed && (t0 + 2 * B2 + k * 64 * B2) < tp) begin
                if (l > 0) l--;
                k++;
            end
            if (i < n) begin
                if (l < DEPTH) l++;
                else o = 1;
                if (!primed && l >= PRIME) begin
                    primed = 1;
                    t0     = tp;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        en_cnt <= en_cnt + (en ? 1 : 0);
        clr_s  <= clr;
        en_s   <= en;
    end

    // Monitor state (written only by the monitor process).
    logic        prev_bclk = 1'b0, prev_lrn = 1'b0, prev_lr = 1'b0;
    logic [2:0]  frz_prev = '0;
    bit          frz_ok = 0, synced = 0, have_l = 0, rise_ok = 0, fall_ok = 0;
    logic [15:0] sr = '0, l_word = '0;
    int unsigned nbits = 0, seen = 0, last_rise = 0, last_fall = 0, words = 0, n2 = 0;

    always @(negedge clk) begin
        exp_t        x;
        logic [15:0] e;
        int unsigned le;
        bit          oe;
        if (clr_s) begin
            synced = 0; have_l = 0; rise_ok = 0; fall_ok = 0; frz_ok = 0;
            nbits = 0; seen = 0; n2 = 0; prev_lr = 1'b0;
        end else begin
            if (sv[0]) begin
                if (samp_q.size() == 0) begin
                    check("sample_unexpected", 32'(so[0]), 32'hFFFF_FFFF);
                end else begin
                    x = samp_q.pop_front();
                    check("sample_out", 32'(so[0]), 32'(x.val));
                    check("sample_valid_cycle", cyc, x.cyc);
                end
                seen++;
            end
            if (!en_s && frz_ok)
                check("frozen_i2s", 32'({bclk[0], lrclk[0], sdata[0]}), 32'(frz_prev));
            if (bclk[0] && !prev_bclk) begin
                check("idle_until_primed", 32'(seen >= PRIME), 32'd1);
                if (rise_ok) check("bclk_period", en_cnt - last_rise, 2 * B0);
                last_rise = en_cnt; rise_ok = 1;
                sr = {sr[14:0], sdata[0]};
                nbits++;
                if (lrclk[0] != prev_lr) begin
                    if (synced) begin
                        check("slot_bits", nbits, 32'd16);
                        if (!prev_lr) begin
                            l_word = sr; have_l = 1;
                        end else begin
                            if (i2s_q.size() == 0) begin
                                check("i2s_word_unexpected", 32'(sr), 32'hFFFF_FFFF);
                            end else begin
                                e = i2s_q.pop_front();
                                check("i2s_right", 32'(sr), 32'(e));
                                if (have_l) check("i2s_left", 32'(l_word), 32'(e));
                                words++;
                            end
                            have_l = 0;
                        end
                    end
                    synced = 1; nbits = 0;
                end
                prev_lr = lrclk[0];
            end
            if (!lrclk[0] && prev_lrn) begin
                if (fall_ok) check("lrclk_period", en_cnt - last_fall, 64 * B0);
                last_fall = en_cnt; fall_ok = 1;
            end
            if (phase_b && sv[1]) begin
                n2++;
                fifo2_model(n2, le, oe);
                check("slow_fifo_level", 32'(lvl[1]), le);
                check("slow_overflow", 32'(ov[1]), 32'(oe));
            end
            frz_ok = 1;
        end
        frz_prev  = {bclk[0], lrclk[0], sdata[0]};
        prev_bclk = bclk[0];
        prev_lrn  = lrclk[0];
    end

    task automatic drive(input logic a, input logic e);
        exp_t x;
        aud = a;
        en  = e;
        if (e) begin
            ones += 32'(a);
            wcnt++;
            if (wcnt == DECIM) begin
                x.val = pcm_of(ones);
                x.cyc = cyc + 1;
                samp_q.push_back(x);
                i2s_q.push_back(x.val);
                wcnt = 0;
                ones = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        samp_q.delete();
        i2s_q.delete();
        wcnt = 0;
        ones = 0;
        for (int g = 0; g < 3; g++)
            check($sformatf("clr_outputs_%0d", g),
                  32'({bclk[g], lrclk[g], sdata[g], sv[g], uf[g], ov[g], lvl[g], so[g]}), 32'd0);
    endtask

    task automatic run_random(input int unsigned cycles, input bit pauses);
        int unsigned dens;
        dens = 50;
        for (int unsigned i = 0; i < cycles; i++) begin
            if (wcnt == 0) dens = $urandom_range(0, 100);
            if (pauses && i == 700)
                repeat (500) drive(1'($urandom_range(0, 1)), 1'b0);
            else if (pauses && $urandom_range(0, 299) == 0)
                repeat ($urandom_range(1, 20)) drive(1'($urandom_range(0, 1)), 1'b0);
            drive(1'($urandom_range(0, 99) < dens), 1'b1);
        end
    endtask

    initial begin
        int unsigned le;
        bit          oe;
        clr = 1'b1;
        aud = 1'b0;
        en  = 1'b0;
        do_clr();

        // Silence: every sample is the most negative code.
        for (int unsigned i = 0; i < 4 * DECIM; i++) drive(1'b0, 1'b1);
        check("flags_after_silence", 32'({uf[0], ov[0]}), 32'd0);

        // Full-scale: saturating accumulator over 20 frames; slow/fast frame instances stress the FIFO.
        do_clr();
        phase_b = 1;
        for (int unsigned i = 0; i < 20 * DECIM; i++) drive(1'b1, 1'b1);
        phase_b = 0;
        check("fullscale_no_underflow", 32'(uf[0]), 32'd0);
        check("fullscale_no_overflow", 32'(ov[0]), 32'd0);
        fifo2_model(21, le, oe);
        check("slow_overflow_end", 32'(ov[1]), 32'(oe));
        check("fast_underflow_end", 32'(uf[2]), 32'd1);

        // 50 % duty PWM then random densities.
        for (int unsigned i = 0; i < 3 * DECIM; i++)
            drive(1'((wcnt % PWM_PERIOD) < (PWM_PERIOD / 2)), 1'b1);
        run_random(2 * DECIM, 1'b0);

        // Enable pauses, including one long 500-cycle freeze mid-frame.
        run_random(3 * DECIM, 1'b1);
        check("pause_no_underflow", 32'(uf[0]), 32'd0);

        // Reset mid-frame with sticky flags set, then re-prime.
        check("sticky_before_clr", 32'({ov[1], uf[2]}), 32'b11);
        do_clr();
        run_random(4 * DECIM, 1'b0);
        repeat (4) drive(1'b0, 1'b0);

        check("samples_drained", samp_q.size(), 32'd0);
        check("i2s_words_decoded", 32'(words > 20), 32'd1);
        check("final_flags", 32'({uf[0], ov[0]}), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
